video_scan: RTL and testbench
=============================

VIDEO_SCAN -- requirements
Module: video_scan

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 1024, visible pixels per line (multiple of 32).
REQ-002 SHALL have parameter H_FP, default 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 136, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 160, horizontal back porch in pixels.
REQ-005 SHALL have parameters V_ACTIVE 768, V_FP 3, V_SYNC 6, V_BP 29, vertical equivalents in lines.
REQ-006 SHALL have parameter BASE, default 16'h0000, word address of the first pixel word.
REQ-007 SHALL have port clk, input, 1, pixel clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port vidadr, output, 16, registered word address to the frame-buffer read port.
REQ-010 SHALL have port viddata, input, 32, frame-buffer read data; valid one clk after vidadr is sampled.
REQ-011 SHALL have ports hsync and vsync, output, 1 each, active-low syncs, registered.
REQ-012 SHALL have port de, output, 1, active-video enable, registered.
REQ-013 SHALL have port pix, output, 1, monochrome pixel, registered.
REQ-014 SHALL have port vblank, output, 1, high when vcount >= V_ACTIVE, registered.

Function
REQ-015 SHALL keep hcount in 0..H_TOTAL-1 (H_TOTAL = sum of H params, 1344), incrementing every clk and wrapping to 0.
REQ-016 SHALL keep vcount in 0..V_TOTAL-1 (806), incrementing only on an hcount wrap and wrapping to 0 when both wrap in the same cycle.
REQ-017 SHALL define the active region as hcount < H_ACTIVE and vcount < V_ACTIVE.
REQ-018 SHALL register vidadr = BASE + vcount*(H_ACTIVE/32) + w at the edge ending cycle hcount == 32*w, for w = 0..H_ACTIVE/32-1, only when vcount < V_ACTIVE.
REQ-019 SHALL hold vidadr unchanged in all other cycles, including blanking.
REQ-020 SHALL load viddata into a 32-bit shift register at the edge ending cycle hcount == 32*w+1 in active lines, otherwise shift right by one with zero fill.
REQ-021 SHALL drive pix from shift-register bit 0; bit 0 of each word is the leftmost pixel.
REQ-022 SHALL have pixel x of line y appear on pix during cycle hcount == x+2 of that line (2-clk pipeline).
REQ-023 SHALL delay de, hsync and vsync by the same 2 clk, so de is high for exactly H_ACTIVE consecutive cycles per active line.
REQ-024 SHALL force pix to 0 whenever de is 0.
REQ-025 SHALL assert hsync low for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] before the 2-clk delay.
REQ-026 SHALL assert vsync low for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] before the 2-clk delay.
REQ-027 SHALL compute vidadr arithmetic modulo 2^16.
REQ-028 SHALL, with the 2-clk delay, let de of the last pixel cross into the next line's cycles 0..1 without error.

Reset
REQ-029 SHALL, while rst is high, hold hcount=0, vcount=0, vidadr=BASE, shift register=0, pix=0, de=0, hsync=1, vsync=1, vblank=0.
REQ-030 SHALL, on rst assertion mid-frame, return all state immediately and asynchronously to REQ-029 values.
REQ-031 SHALL, after rst deassertion, start counting at the next clk edge with hcount=0, vcount=0.

Verification
REQ-032 SHALL cover: release reset, count edges -> first hsync low after 1048+2 edges, lasting 136 clk; period 1344 clk.
REQ-033 SHALL cover: run a full frame -> vsync low for 6*1344 clk starting at line 771; frame period 1083264 clk.
REQ-034 SHALL cover: memory model returns 32'h0000_0001 at BASE, 0 elsewhere -> pix high only at line 0, pixel 0 (hcount 2).
REQ-035 SHALL cover: viddata = 32'h8000_0000 at BASE+33 -> pix high at line 1, pixel 63; vidadr sequence on line 1 runs 32..63.
REQ-036 SHALL cover: memory returns all ones -> de and pix high for exactly 1024 clk per line, 768 lines, pix=0 in blanking.
REQ-037 SHALL cover: assert rst at line 400, hcount 500, for 3 clk -> all outputs at reset values within the cycle; restart from vidadr=BASE.

Source files
------------

// File: rtl/video_scan.sv
// Raster scan generator for a 1 bpp monochrome frame buffer: free-running h/v counters,
// one 32-pixel word fetched per 32 clocks, and syncs/de/pix aligned through a 2-clk pipeline.
module video_scan #(
   parameter int          H_ACTIVE = 1024,
   parameter int          H_FP     = 24,
   parameter int          H_SYNC   = 136,
   parameter int          H_BP     = 160,
   parameter int          V_ACTIVE = 768,
   parameter int          V_FP     = 3,
   parameter int          V_SYNC   = 6,
   parameter int          V_BP     = 29,
   parameter logic [15:0] BASE     = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] vidadr,
   input  logic [31:0] viddata,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic        pix,
   output logic        vblank
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [15:0]   WORDS_LINE = 16'(H_ACTIVE / 32);

   logic [HW-1:0] hcount_q, hcount_d;
   logic [VW-1:0] vcount_q, vcount_d;
   logic [15:0]   line_base_q, line_base_d;
   logic [15:0]   vidadr_q, vidadr_d;
   logic [31:0]   shreg_q, shreg_d;
   logic [1:0]    de_pipe_q, de_pipe_d;
   logic [1:0]    hs_pipe_q, hs_pipe_d;
   logic [1:0]    vs_pipe_q, vs_pipe_d;
   logic          pix_q, pix_d;
   logic          vblank_q, vblank_d;

   logic h_wrap, v_wrap, active, fetch, load;

   // line_base tracks the first word address of the current line, so no multiplier is needed
   always_comb begin
      h_wrap      = (hcount_q == H_LAST);
      v_wrap      = (vcount_q == V_LAST);
      hcount_d    = h_wrap ? '0 : hcount_q + 1'b1;
      vcount_d    = vcount_q;
      line_base_d = line_base_q;
      if (h_wrap) begin
         if (v_wrap) begin
            vcount_d    = '0;
            line_base_d = BASE;
         end else begin
            vcount_d    = vcount_q + 1'b1;
            line_base_d = line_base_q + WORDS_LINE;
         end
      end

      active = (hcount_q < H_ACT) && (vcount_q < V_ACT);
      fetch  = active && (hcount_q[4:0] == 5'd0);
      load   = active && (hcount_q[4:0] == 5'd1);

      vidadr_d  = fetch ? line_base_q + 16'(hcount_q >> 5) : vidadr_q;
      shreg_d   = load ? viddata : {1'b0, shreg_q[31:1]};
      de_pipe_d = {de_pipe_q[0], active};
      hs_pipe_d = {hs_pipe_q[0], !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST))};
      vs_pipe_d = {vs_pipe_q[0], !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST))};

      // pix lands in the same cycle as the delayed de, gated so blanking is always dark
      pix_d    = shreg_d[0] & de_pipe_q[0];
      vblank_d = (vcount_d >= V_ACT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q    <= '0;
         vcount_q    <= '0;
         line_base_q <= BASE;
         vidadr_q    <= BASE;
         shreg_q     <= '0;
         de_pipe_q   <= 2'b00;
         hs_pipe_q   <= 2'b11;
         vs_pipe_q   <= 2'b11;
         pix_q       <= 1'b0;
         vblank_q    <= 1'b0;
      end else begin
         hcount_q    <= hcount_d;
         vcount_q    <= vcount_d;
         line_base_q <= line_base_d;
         vidadr_q    <= vidadr_d;
         shreg_q     <= shreg_d;
         de_pipe_q   <= de_pipe_d;
         hs_pipe_q   <= hs_pipe_d;
         vs_pipe_q   <= vs_pipe_d;
         pix_q       <= pix_d;
         vblank_q    <= vblank_d;
      end
   end

   assign vidadr = vidadr_q;
   assign hsync  = hs_pipe_q[1];
   assign vsync  = vs_pipe_q[1];
   assign de     = de_pipe_q[1];
   assign pix    = pix_q;
   assign vblank = vblank_q;

endmodule

// File: tb/tb_video_scan.sv
// Scoreboard bench for video_scan on a shrunken raster: expected de/sync/pix vectors are queued
// per raster cycle and popped two clocks later when the DUT should present them.
module tb_video_scan;

   localparam int          H_ACTIVE = 64;
   localparam int          H_FP     = 0;
   localparam int          H_SYNC   = 1;
   localparam int          H_BP     = 0;
   localparam int          V_ACTIVE = 6;
   localparam int          V_FP     = 1;
   localparam int          V_SYNC   = 2;
   localparam int          V_BP     = 1;
   localparam logic [15:0] BASE     = 16'hFFFC;
   localparam int          H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int          WPL      = H_ACTIVE / 32;
   localparam int          FRAME    = H_TOTAL * V_TOTAL;

   typedef struct packed {
      logic de;
      logic hs;
      logic vs;
      logic pix;
   } outVec_t;

   logic        clk;
   logic        rst;
   logic [15:0] vidadr;
   logic [31:0] viddata;
   logic        hsync, vsync, de, pix, vblank;

   int          memMode;
   int          hc, vc;
   int          edgesSinceReset;
   int          firstHsLow, firstVsLow;
   int          vsLowCount, deHighCount, pixHighCount;
   int          checks, passes;
   logic [15:0] expVidadr;
   outVec_t     expQ[$];

   video_scan #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .BASE(BASE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .vidadr(vidadr),
      .viddata(viddata),
      .hsync(hsync),
      .vsync(vsync),
      .de(de),
      .pix(pix),
      .vblank(vblank)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame-buffer contents: mode 0 = two marker words, mode 1 = all ones, mode 2 = address hash
   function automatic logic [31:0] memWord(input logic [15:0] addr, input int mode);
      logic [15:0] markB;
      markB = BASE + 16'd3;
      case (mode)
         0: begin
            if (addr == BASE)       return 32'h0000_0001;
            else if (addr == markB) return 32'h8000_0000;
            else                    return 32'h0;
         end
         1:       return 32'hFFFF_FFFF;
         default: return {addr, addr ^ 16'hA5C3} ^ 32'h3C96_5A0F;
      endcase
   endfunction

   always_comb viddata = memWord(vidadr, memMode);

   function automatic logic pixelAt(input int x, input int y);
      logic [15:0] addr;
      logic [31:0] w;
      addr = BASE + 16'(y * WPL + x / 32);
      w    = memWord(addr, memMode);
      return w[x % 32];
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkValue(tag, {11'b0, vidadr, de, pix, hsync, vsync, vblank},
                 {11'b0, BASE, 5'b00110});
   endtask

   // One raster cycle: queue this cycle's expectation, compare the one due now, update stats
   task automatic checkOutput();
      outVec_t e;
      outVec_t o;
      outVec_t due;
      e.de  = (hc < H_ACTIVE) && (vc < V_ACTIVE);
      e.hs  = !((hc >= H_ACTIVE + H_FP) && (hc < H_ACTIVE + H_FP + H_SYNC));
      e.vs  = !((vc >= V_ACTIVE + V_FP) && (vc < V_ACTIVE + V_FP + V_SYNC));
      e.pix = e.de && pixelAt(hc, vc);
      expQ.push_back(e);
      o = {de, hsync, vsync, pix};
      if (expQ.size() > 2) begin
         due = expQ.pop_front();
         checkValue($sformatf("pipe v%0d h%0d", vc, hc), {28'b0, o}, {28'b0, due});
      end
      checkValue($sformatf("vidadr v%0d h%0d", vc, hc), {16'b0, vidadr}, {16'b0, expVidadr});
      if (hc == 32)
         checkValue($sformatf("vblank v%0d", vc), {31'b0, vblank}, {31'b0, vc >= V_ACTIVE});
      if (!hsync && firstHsLow < 0) firstHsLow = edgesSinceReset;
      if (!vsync && firstVsLow < 0) firstVsLow = edgesSinceReset;
      vsLowCount   += int'(!vsync);
      deHighCount  += int'(de);
      pixHighCount += int'(pix);
      if ((hc < H_ACTIVE) && (vc < V_ACTIVE) && (hc % 32 == 0))
         expVidadr = BASE + 16'(vc * WPL + hc / 32);
   endtask

   task automatic advanceClock();
      @(posedge clk);
      edgesSinceReset++;
      if (hc == H_TOTAL - 1) begin
         hc = 0;
         vc = (vc == V_TOTAL - 1) ? 0 : vc + 1;
      end else begin
         hc++;
      end
      @(negedge clk);
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) begin
         checkOutput();
         advanceClock();
      end
   endtask

   // Assert reset right now (between edges), hold it, release on a falling edge, restart the model
   task automatic applyStimulus(input int mode, input int holdCycles);
      rst     = 1'b1;
      memMode = mode;
      #1;
      checkResetState("reset_immediate");
      for (int i = 0; i < holdCycles; i++) begin
         @(posedge clk);
         #1;
         checkResetState($sformatf("reset_held_%0d", i));
      end
      @(negedge clk);
      rst = 1'b0;
      hc = 0;
      vc = 0;
      expVidadr = BASE;
      expQ.delete();
      expQ.push_back(outVec_t'(4'b0110));
      expQ.push_back(outVec_t'(4'b0110));
      edgesSinceReset = 0;
      firstHsLow   = -1;
      firstVsLow   = -1;
      vsLowCount   = 0;
      deHighCount  = 0;
      pixHighCount = 0;
   endtask

   initial begin
      checks  = 0;
      passes  = 0;
      memMode = 0;
      rst     = 1'b1;

      // Marker words: only line 0 pixel 0 and line 1 pixel 63 may light up
      applyStimulus(0, 3);
      runCycles(FRAME);
      checkValue("first_hsync_edges", firstHsLow, H_ACTIVE + H_FP + 2);
      checkValue("first_vsync_edges", firstVsLow, (V_ACTIVE + V_FP) * H_TOTAL + 2);
      checkValue("vsync_low_cycles", vsLowCount, V_SYNC * H_TOTAL);
      checkValue("de_high_cycles_m0", deHighCount, H_ACTIVE * V_ACTIVE);
      checkValue("pix_high_cycles_m0", pixHighCount, 2);

      // All-ones memory: pix must follow de exactly
      applyStimulus(1, 2);
      runCycles(FRAME);
      checkValue("de_high_cycles_m1", deHighCount, H_ACTIVE * V_ACTIVE);
      checkValue("pix_high_cycles_m1", pixHighCount, H_ACTIVE * V_ACTIVE);

      // Hashed pattern, interrupted mid-frame at line 3 pixel 40 by a 3-clk reset
      applyStimulus(2, 1);
      runCycles(3 * H_TOTAL + 40);
      applyStimulus(2, 3);
      runCycles(FRAME);
      checkValue("restart_first_hsync", firstHsLow, H_ACTIVE + H_FP + 2);
      checkValue("de_high_cycles_m2", deHighCount, H_ACTIVE * V_ACTIVE);
      runCycles(2 * H_TOTAL);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
